// File: rtl/ulpi_pkg.sv
// Shared TX CMD encodings and sequencer state type for ULPI register access.
package ulpi_pkg;

  localparam logic [1:0] CMD_REGW = 2'b10;
  localparam logic [1:0] CMD_REGR = 2'b11;
  localparam logic [7:0] CMD_NOOP = 8'h00;

  typedef enum logic [3:0] {
    StIdle,
    StTxCmd,
    StWData,
    StStp,
    StRdTurn1,
    StRdData,
    StRdTurn2,
    StAbort,
    StAbortTurn,
    StFailStp
  } ulpi_state_e;

  function automatic logic [7:0] reg_cmd(input logic rw, input logic [5:0] addr);
    return {(rw ? CMD_REGR : CMD_REGW), addr};
  endfunction

endpackage

// File: rtl/ulpi_wait_timer.sv
// Clearable saturating up-counter; expired_o is high on the Limit-th cycle since the last clear.
module ulpi_wait_timer #(
  parameter int unsigned CntW  = 8,
  parameter int unsigned Limit = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic expired_o
);

  localparam logic [CntW-1:0] Last = CntW'(Limit - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q != Last) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == Last);

endmodule

// File: rtl/ulpi_reg_ctrl.sv
// ULPI link-side register read/write sequencer: TX CMD, NXT throttle, STP, read turnaround,
// DIR-abort retry and per-wait-state timeout.
module ulpi_reg_ctrl
  import ulpi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       ULPI_CLK,
  input  logic       ULPI_RST_N,
  input  logic       ULPI_DIR,
  input  logic       ULPI_NXT,
  input  logic [7:0] ULPI_DATA_I,
  output logic [7:0] ULPI_DATA_O,
  output logic       ULPI_DATA_OE,
  output logic       ULPI_STP,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_RW,
  input  logic [5:0] REQ_ADDR,
  input  logic [7:0] REQ_WDATA,
  output logic [7:0] RD_DATA,
  output logic       DONE,
  output logic       ERR
);

  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  ulpi_state_e       state_q, state_d;
  logic              rw_q, rw_d;
  logic [5:0]        addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic [7:0]        data_o;
  logic              oe_raw;
  logic              stp;
  logic              tmo;

  ulpi_wait_timer #(
    .CntW  (CNT_W),
    .Limit (TIMEOUT_CYC)
  ) u_wait_timer (
    .clk_i     (ULPI_CLK),
    .rst_ni    (ULPI_RST_N),
    .clr_i     (state_d != state_q),
    .expired_o (tmo)
  );

  always_comb begin
    state_d   = state_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    retry_d   = retry_q;
    rd_data_d = rd_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    data_o    = CMD_NOOP;
    oe_raw    = 1'b0;
    stp       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ready_q && REQ_VALID) begin
          state_d = StTxCmd;
          rw_d    = REQ_RW;
          addr_d  = REQ_ADDR;
          wdata_d = REQ_WDATA;
          retry_d = '0;
        end
      end
      StTxCmd: begin
        data_o = reg_cmd(rw_q, addr_q);
        oe_raw = 1'b1;
        // DIR wins over a simultaneous NXT
        if (ULPI_DIR) begin
          state_d = StAbort;
        end else if (ULPI_NXT) begin
          state_d = rw_q ? StRdTurn1 : StWData;
        end else if (tmo) begin
          state_d = StFailStp;
        end
      end
      StWData: begin
        data_o = wdata_q;
        oe_raw = 1'b1;
        if (ULPI_DIR) begin
          state_d = StAbort;
        end else if (ULPI_NXT) begin
          state_d = StStp;
        end else if (tmo) begin
          state_d = StFailStp;
        end
      end
      StStp, StFailStp: begin
        stp     = 1'b1;
        oe_raw  = 1'b1;
        state_d = StIdle;
        done_d  = 1'b1;
        err_d   = (state_q == StFailStp);
      end
      StRdTurn1: begin
        if (ULPI_DIR) begin
          state_d = StRdData;
        end else if (tmo) begin
          state_d = StIdle;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      StRdData: begin
        if (ULPI_DIR) begin
          rd_data_d = ULPI_DATA_I;
          done_d    = 1'b1;
          state_d   = StRdTurn2;
        end else begin
          state_d = StAbort;
        end
      end
      StRdTurn2: begin
        if (!ULPI_DIR) begin
          state_d = StIdle;
        end else if (tmo) begin
          state_d = StIdle;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      StAbort: begin
        if (!ULPI_DIR) begin
          state_d = StAbortTurn;
        end else if (tmo) begin
          state_d = StIdle;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      StAbortTurn: begin
        if (retry_q < RetryW'(MAX_RETRY)) begin
          retry_d = retry_q + RetryW'(1);
          state_d = StTxCmd;
        end else begin
          state_d = StIdle;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    ready_d = (state_d == StIdle) && !ULPI_DIR;
  end

  always_ff @(posedge ULPI_CLK or negedge ULPI_RST_N) begin
    if (!ULPI_RST_N) begin
      state_q   <= StIdle;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      retry_q   <= '0;
      rd_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      retry_q   <= retry_d;
      rd_data_q <= rd_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
    end
  end

  // Bus outputs decode from state so they follow reset asynchronously; DIR gates OE at once.
  assign ULPI_DATA_O  = data_o;
  assign ULPI_DATA_OE = oe_raw & ~ULPI_DIR;
  assign ULPI_STP     = stp;
  assign REQ_READY    = ready_q;
  assign RD_DATA      = rd_data_q;
  assign DONE         = done_q;
  assign ERR          = err_q;

endmodule

// File: doc/ulpi_reg_ctrl.md
Name: ulpi_reg_ctrl

Overview:
Link-side sequencer for ULPI PHY register access (TX CMD REGW/REGR). Accepts one register read or write request at a time from the application and runs the full ULPI bus handshake: TX CMD, NXT wait, data phase, STP, and read turnaround. It drives the data bus through split output and output-enable signals, and a top-level tristate resolves them onto ULPI_DATA. Aborts caused by PHY DIR assertion are retried, and hung handshakes are bounded by a timeout.

Parameters:
TIMEOUT_CYC, 255, max ULPI_CLK cycles spent in any single wait state before the access fails
MAX_RETRY, 3, number of DIR-abort retries allowed before the access fails
CNT_W, 8, timeout counter width; must satisfy 2**CNT_W > TIMEOUT_CYC

Ports:
ULPI_CLK  in  1  PHY-sourced clock, 60 MHz
ULPI_RST_N  in  1  asynchronous active-low reset
ULPI_DIR  in  1  bus direction from PHY (1 = PHY drives)
ULPI_NXT  in  1  PHY next/throttle
ULPI_DATA_I  in  8  sampled ULPI_DATA
ULPI_DATA_O  out  8  value the link drives on ULPI_DATA
ULPI_DATA_OE  out  1  link output enable; always forced 0 when ULPI_DIR=1 (combinational gate)
ULPI_STP  out  1  stop strobe to PHY
REQ_VALID  in  1  request present
REQ_READY  out  1  request accepted when VALID&READY
REQ_RW  in  1  1 = read, 0 = write
REQ_ADDR  in  6  PHY immediate register address
REQ_WDATA  in  8  write data
RD_DATA  out  8  read result; held until the next completed read
DONE  out  1  one-cycle completion pulse
ERR  out  1  one-cycle pulse coincident with DONE on a failed access

Behaviour:
- Reset values: ULPI_DATA_O=00, ULPI_DATA_OE=0, ULPI_STP=0, REQ_READY=0, RD_DATA=00, DONE=0, ERR=0. State=IDLE. Counters are cleared.
- Reset asserted mid-access: immediate return to IDLE. OE drops asynchronously. STP is not issued.
- REQ_READY=1 only in IDLE with ULPI_DIR=0 (registered). On accept, RW, ADDR and WDATA are latched and the retry counter is cleared.
- The timeout counter clears on every state change. If it reaches TIMEOUT_CYC in any wait state: DONE=ERR=1 for one cycle, then IDLE. A timeout in WDATA or TXCMD also drives one STP cycle with DATA_O=00 first.
- TXCMD: DATA_O={2'b10,ADDR} for a write, {2'b11,ADDR} for a read; OE=1. Sampled NXT=1 & DIR=0 moves to WDATA (write) or RD_TURN1 (read). Sampled DIR=1 moves to ABORT.
- WDATA: DATA_O=WDATA, OE=1. Sampled NXT=1 moves to STP. DIR=1 moves to ABORT.
- STP: ULPI_STP=1, DATA_O=00, OE=1 for exactly one cycle. Next cycle: IDLE with DONE=1. Write latency with zero-wait NXT is accept+4 cycles to DONE.
- RD_TURN1: OE=0; waits for DIR=1 (turnaround), then RD_DATA.
- RD_DATA: RD_DATA<=ULPI_DATA_I, DONE=1 next cycle, then RD_TURN2. If DIR=0 is sampled here, it is treated as an abort.
- RD_TURN2: waits for DIR=0 (turnaround back), then IDLE. REQ_READY cannot assert earlier than the cycle after DIR falls.
- ABORT: OE=0. Waits for DIR=0 plus one turnaround cycle. If the retry count < MAX_RETRY, increment it and re-enter TXCMD with the latched request. Otherwise DONE=ERR=1, then IDLE.
- DIR and NXT both rising in the same TXCMD cycle counts as an abort, not an accept.
- RX CMD/packet data received while idle is ignored here; a separate receiver consumes it.

Decomposition:
- Shared package ulpi_pkg: TX CMD prefix constants (CMD_REGW=2'b10, CMD_REGR=2'b11, CMD_NOOP=8'h00) and the state encoding enum.
- Sub-module ulpi_wait_timer: clearable up-counter with an expired flag, reused for the timeout.
- Retry counting stays inline in the FSM.

Test Plan:
- Write addr=0x0A data=0x45, NXT=1 on the first TXCMD cycle and in WDATA -> DATA_O sequence 0x8A, 0x45, 0x00 with STP=1 on the third; DONE 1 cycle later; ERR=0.
- Read addr=0x16, PHY NXT then DIR=1 turnaround, data 0xC3 -> DATA_O 0xD6 with OE=1; OE=0 during turnaround; RD_DATA=0xC3; DONE pulse; REQ_READY returns only after DIR=0.
- Write with NXT withheld 3 cycles in TXCMD and 2 in WDATA -> DATA_O held stable throughout; no STP before NXT; DONE=1, ERR=0.
- DIR asserted in TXCMD on the first two attempts -> OE=0 within the same cycle; TXCMD reissued twice; the third attempt completes with ERR=0. With 4 aborts (MAX_RETRY=3) -> DONE=ERR=1.
- NXT never asserted, TIMEOUT_CYC=16 -> one STP cycle, then DONE=ERR=1 at 17 cycles after TXCMD entry; REQ_READY=1 afterwards.
- ULPI_RST_N pulled low during WDATA -> all outputs at reset values immediately; a new write after release completes normally.
